// File: rtl/sync_filter_multi.sv
// Multi-channel async-input synchroniser with a persistence (glitch) filter
// and registered rise/fall pulses per channel.
`timescale 1ps/1ps
module sync_filter_multi #(
  parameter int unsigned       NUM_CH     = 4,
  parameter int unsigned       STAGES     = 2,
  parameter int unsigned       FILTER_LEN = 1,
  parameter logic [NUM_CH-1:0] RESET_VAL  = '0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse
);

  localparam int unsigned      CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  if (NUM_CH == 0) begin : g_bad_num_ch
    $error("sync_filter_multi: NUM_CH must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filter_multi: STAGES must be >= 2");
  end
  if (FILTER_LEN == 0) begin : g_bad_filter_len
    $error("sync_filter_multi: FILTER_LEN must be >= 1");
  end

  logic [STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0]             out_q, out_d;
  logic [NUM_CH-1:0]             rise_q, rise_d;
  logic [NUM_CH-1:0]             fall_q, fall_d;
  logic [NUM_CH-1:0]             raw_c;
  logic [NUM_CH-1:0]             update_c;

  assign raw_c = sync_q[STAGES-1];

  // Plain shift chain: nothing but flops between the pin and raw_c.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = async_in;
    for (int unsigned k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // A differing raw level must persist FILTER_LEN cycles before it is taken.
  always_comb begin
    cnt_d    = cnt_q;
    out_d    = out_q;
    update_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (raw_c[i] != out_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          update_c[i] = 1'b1;
          out_d[i]    = raw_c[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    rise_d = update_c & raw_c;
    fall_d = update_c & ~raw_c;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      cnt_q  <= '0;
      out_q  <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sync_out   = out_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_sync_filter_multi.sv
// Scoreboard bench for sync_filter_multi: stimulus pushes expected pulse
// events (cycle window + values), a monitor pops them as pulses appear.
`timescale 1ps/1ps
module tb_sync_filter_multi;

  localparam int unsigned NUM_CH = 4;

  logic              clk;
  logic              n_rst;
  logic [NUM_CH-1:0] async_in;
  logic [NUM_CH-1:0] sync_out;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;

  typedef struct {
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] lvl;
    int                lo;
    int                hi;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  sync_filter_multi #(
    .NUM_CH    (4),
    .STAGES    (2),
    .FILTER_LEN(3),
    .RESET_VAL (4'b0101)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .async_in  (async_in),
    .sync_out  (sync_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #500 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string what);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s", what);
  endtask

  task automatic expect_evt(input logic [NUM_CH-1:0] r, input logic [NUM_CH-1:0] f,
                            input logic [NUM_CH-1:0] l, input int lo, input int hi);
    exp_t e;
    e.rise = r; e.fall = f; e.lvl = l; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic idle_check(input string name, input logic [NUM_CH-1:0] lvl);
    check(sync_out === lvl && rise_pulse === '0 && fall_pulse === '0,
          $sformatf("%s: sync_out=%b rise=%b fall=%b, required sync_out=%b pulses=0000",
                    name, sync_out, rise_pulse, fall_pulse, lvl));
  endtask

  // Monitor: samples 190ps before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #810;
      if (mon_en) begin
        check(!$isunknown({sync_out, rise_pulse, fall_pulse}),
              $sformatf("known_outputs: cyc=%0d sync_out=%b rise=%b fall=%b",
                        cyc, sync_out, rise_pulse, fall_pulse));
        if ((rise_pulse | fall_pulse) != '0) begin
          if (sb.size() == 0) begin
            check(1'b0, $sformatf("unexpected_pulse: cyc=%0d rise=%b fall=%b, required none",
                                  cyc, rise_pulse, fall_pulse));
          end else begin
            e = sb.pop_front();
            check(cyc >= e.lo && cyc <= e.hi && rise_pulse === e.rise &&
                  fall_pulse === e.fall && sync_out === e.lvl,
                  $sformatf("pulse_event: cyc=%0d rise=%b fall=%b sync_out=%b, required cyc %0d..%0d rise=%b fall=%b sync_out=%b",
                            cyc, rise_pulse, fall_pulse, sync_out, e.lo, e.hi, e.rise, e.fall, e.lvl));
          end
        end else if (sb.size() > 0 && cyc >= sb[0].hi) begin
          e = sb.pop_front();
          check(1'b0, $sformatf("missing_pulse: cyc=%0d no pulse, required rise=%b fall=%b by cyc %0d",
                                cyc, e.rise, e.fall, e.hi));
        end
      end
    end
  end

  initial begin
    int c;
    n_rst    = 1'b1;
    async_in = 4'b1010;
    repeat (2) @(posedge clk);

    // Reset asserted mid-cycle takes effect without a clock and holds.
    #300;
    n_rst = 1'b0;
    #1;
    idle_check("reset_immediate", 4'b0101);
    repeat (2) begin
      @(posedge clk);
      #810;
      idle_check("reset_held", 4'b0101);
    end
    @(negedge clk);
    async_in = 4'b0101;
    n_rst    = 1'b1;
    mon_en   = 1'b1;
    repeat (8) @(negedge clk);
    idle_check("after_release", 4'b0101);

    // Latency: ch1 rise appears exactly 5 edges later, not at 4.
    c = cyc;
    async_in = 4'b0111;
    expect_evt(4'b0010, 4'b0000, 4'b0111, c + 5, c + 5);
    repeat (4) @(negedge clk);
    idle_check("latency_not_early", 4'b0101);
    repeat (4) @(negedge clk);

    c = cyc;
    async_in = 4'b0101;
    expect_evt(4'b0000, 4'b0010, 4'b0101, c + 5, c + 5);
    repeat (8) @(negedge clk);

    // Simultaneous ch0 fall and ch1 rise.
    c = cyc;
    async_in = 4'b0110;
    expect_evt(4'b0010, 4'b0001, 4'b0110, c + 5, c + 5);
    repeat (8) @(negedge clk);

    // Glitch on ch3: 2 cycles rejected, 3 cycles accepted (then falls back).
    async_in = 4'b1110;
    repeat (2) @(negedge clk);
    async_in = 4'b0110;
    repeat (8) @(negedge clk);
    idle_check("glitch_rejected", 4'b0110);
    c = cyc;
    async_in = 4'b1110;
    expect_evt(4'b1000, 4'b0000, 4'b1110, c + 5, c + 5);
    repeat (3) @(negedge clk);
    async_in = 4'b0110;
    expect_evt(4'b0000, 4'b1000, 4'b0110, c + 8, c + 8);
    repeat (10) @(negedge clk);

    // Reset mid-filter: ch1 count discarded, full latency after release.
    n_rst    = 1'b0;
    async_in = 4'b0101;
    #1;
    idle_check("reset_again", 4'b0101);
    #199;
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    c = cyc;
    async_in = 4'b0111;
    expect_evt(4'b0010, 4'b0000, 4'b0111, c + 9, c + 9);
    repeat (4) @(negedge clk);
    n_rst = 1'b0;
    #50;
    idle_check("reset_mid_filter", 4'b0101);
    #100;
    n_rst = 1'b1;
    repeat (10) @(negedge clk);

    // Near-edge toggles of ch2: 95ps before an edge, then 50ps after one.
    c = cyc;
    #405;
    async_in = 4'b0011;
    expect_evt(4'b0000, 4'b0100, 4'b0011, c + 5, c + 6);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #50;
    c = cyc;
    async_in = 4'b0111;
    expect_evt(4'b0100, 4'b0000, 4'b0111, c + 4, c + 5);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check(sb.size() == 0, $sformatf("scoreboard_drained: %0d events left, required 0", sb.size()));
    idle_check("final_level", 4'b0111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
